// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the 5-stage MIPS pipeline. It accepts a load or
//   store from the EX/MEM stage, models a memory with a fixed multi-cycle
//   latency, and holds the pipeline with mem_busy until the access completes.
//
// Parameters
//   ADDR_W   word-address width; the array holds 2**ADDR_W 32-bit words
//   LATENCY  cycles from request to completion (1..15)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   MemRead    in   1   load request
//   MemWrite   in   1   store request
//   Addr       in   32  byte address
//   WriteData  in   32  store data
//   ReadData   out  32  load data, registered, holds between loads
//   rd_valid   out  1   one-cycle pulse: ReadData updated by a completing load
//   mem_busy   out  1   pipeline hold while a request is outstanding
//   mem_err    out  1   one-cycle pulse: completing request was illegal
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        rd_valid,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // WAIT already accounts for the sampling cycle and the DONE cycle.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    // Illegal: misaligned, beyond the array, or load and store together.
    function automatic logic is_illegal(input logic [31:0] addr,
                                        input logic        rd,
                                        input logic        wr);
        logic bad_align;
        logic bad_range;
        bad_align  = (addr[1:0] != 2'b00);
        bad_range  = ((addr >> (ADDR_W + 2)) != 32'd0);
        is_illegal = bad_align | bad_range | (rd & wr);
    endfunction

    logic [31:0]       mem_r [0:(2**ADDR_W)-1];

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nx_s;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;
    logic              op_rd_r;
    logic              op_wr_r;
    logic              illegal_r;
    logic [31:0]       rdata_r;
    logic              rd_valid_r;
    logic              mem_err_r;

    logic              req_s;
    logic              enter_done_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       sel_data_s;
    logic              sel_rd_s;
    logic              sel_wr_s;
    logic              sel_ill_s;
    logic [ADDR_W-1:0] sel_word_s;

    assign req_s = MemRead | MemWrite;

    // Next-state and countdown logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (LATENCY == 1) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_WAIT;
                        cnt_nx_s   = CNT_INIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = ST_DONE;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // DONE always returns to IDLE, so any move into DONE is a fresh completion.
    assign enter_done_s = (state_nx_s == ST_DONE);

    // Access operands: with LATENCY 1 the completing edge is also the sampling
    // edge, so IDLE uses the live inputs; otherwise the latched copy is used.
    always_comb begin
        sel_addr_s = addr_r;
        sel_data_s = wdata_r;
        sel_rd_s   = op_rd_r;
        sel_wr_s   = op_wr_r;
        sel_ill_s  = illegal_r;
        if (state_r == ST_IDLE) begin
            sel_addr_s = Addr;
            sel_data_s = WriteData;
            sel_rd_s   = MemRead;
            sel_wr_s   = MemWrite;
            sel_ill_s  = is_illegal(Addr, MemRead, MemWrite);
        end else begin
            sel_addr_s = addr_r;
            sel_data_s = wdata_r;
            sel_rd_s   = op_rd_r;
            sel_wr_s   = op_wr_r;
            sel_ill_s  = illegal_r;
        end
    end

    assign sel_word_s = sel_addr_s[ADDR_W+1:2];

    // Control state, request latch, load data and completion pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            op_rd_r    <= 1'b0;
            op_wr_r    <= 1'b0;
            illegal_r  <= 1'b0;
            rdata_r    <= 32'd0;
            rd_valid_r <= 1'b0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            rd_valid_r <= enter_done_s & sel_rd_s & ~sel_ill_s;
            mem_err_r  <= enter_done_s & sel_ill_s;
            if ((state_r == ST_IDLE) && req_s) begin
                addr_r    <= Addr;
                wdata_r   <= WriteData;
                op_rd_r   <= MemRead;
                op_wr_r   <= MemWrite;
                illegal_r <= is_illegal(Addr, MemRead, MemWrite);
            end
            if (enter_done_s && sel_rd_s && !sel_ill_s) begin
                rdata_r <= mem_r[sel_word_s];
            end
        end
    end

    // Array write; gated by rst_n so a store caught by reset is dropped.
    // The array itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && enter_done_s && sel_wr_s && !sel_ill_s) begin
            mem_r[sel_word_s] <= sel_data_s;
        end
    end

    assign ReadData = rdata_r;
    assign rd_valid = rd_valid_r;
    assign mem_err  = mem_err_r;
    assign mem_busy = rst_n & (((state_r == ST_IDLE) & req_s) | (state_r == ST_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        rd2, wr2;
    logic [31:0] a2, d2;
    logic [31:0] q2;
    logic        rv2, busy2, err2;

    logic        rd1, wr1;
    logic [31:0] a1, d1;
    logic [31:0] q1;
    logic        rv1, busy1, err1;

    int checks;
    int errors;

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd2), .MemWrite(wr2),
        .Addr(a2), .WriteData(d2), .ReadData(q2), .rd_valid(rv2),
        .mem_busy(busy2), .mem_err(err2)
    );

    dmem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd1), .MemWrite(wr1),
        .Addr(a1), .WriteData(d1), .ReadData(q1), .rd_valid(rv1),
        .mem_busy(busy1), .mem_err(err1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One LATENCY=2 transaction starting in the current cycle (c0).
    // alt_addr/alt_data are presented in c1 and must be ignored.
    task automatic do2(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] alt_addr, input logic [31:0] alt_data,
                       input logic exp_v, input logic exp_e, input logic [31:0] exp_q);
        rd2 = rd; wr2 = wr; a2 = addr; d2 = wdata;
        #1;
        chk({tag, ".busy0"}, 32'(busy2), 32'd1);
        chk({tag, ".rv0"},   32'(rv2),   32'd0);
        tick();
        a2 = alt_addr; d2 = alt_data;
        #1;
        chk({tag, ".busy1"}, 32'(busy2), 32'd1);
        tick();
        chk({tag, ".busy2"}, 32'(busy2), 32'd0);
        chk({tag, ".rv2"},   32'(rv2),   32'(exp_v));
        chk({tag, ".err2"},  32'(err2),  32'(exp_e));
        chk({tag, ".q2"},    q2,         exp_q);
        tick();
        rd2 = 1'b0; wr2 = 1'b0;
        #1;
        chk({tag, ".rv3"},   32'(rv2),   32'd0);
        chk({tag, ".err3"},  32'(err2),  32'd0);
        chk({tag, ".busy3"}, 32'(busy2), 32'd0);
    endtask

    // One LATENCY=1 transaction; the next one may start right on return.
    task automatic do1(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_v, input logic [31:0] exp_q);
        rd1 = rd; wr1 = wr; a1 = addr; d1 = wdata;
        #1;
        chk({tag, ".busy0"}, 32'(busy1), 32'd1);
        chk({tag, ".rv0"},   32'(rv1),   32'd0);
        tick();
        chk({tag, ".busy1"}, 32'(busy1), 32'd0);
        chk({tag, ".rv1"},   32'(rv1),   32'(exp_v));
        chk({tag, ".err1"},  32'(err1),  32'd0);
        chk({tag, ".q1"},    q1,         exp_q);
        tick();
        rd1 = 1'b0; wr1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rd2 = 1'b0; wr2 = 1'b0; a2 = 32'd0; d2 = 32'd0;
        rd1 = 1'b1; wr1 = 1'b0; a1 = 32'd0; d1 = 32'd0;
        tick();
        tick();
        // Reset state, with a request held on dut1 to show busy is gated.
        chk("rst.q2",    q2,          32'd0);
        chk("rst.rv2",   32'(rv2),    32'd0);
        chk("rst.err2",  32'(err2),   32'd0);
        chk("rst.busy2", 32'(busy2),  32'd0);
        chk("rst.busy1", 32'(busy1),  32'd0);
        rd1 = 1'b0;
        rst_n = 1'b1;
        tick();

        // Store then load, LATENCY=2.
        do2("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        do2("ld10", 1'b1, 1'b0, 32'h10, 32'd0, 32'h10, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        do2("st00", 1'b0, 1'b1, 32'h0, 32'hA5A50000, 32'h0, 32'hA5A50000, 1'b0, 1'b0, 32'hDEADBEEF);
        do2("st18", 1'b0, 1'b1, 32'h18, 32'h0BADF00D, 32'h18, 32'h0BADF00D, 1'b0, 1'b0, 32'hDEADBEEF);
        do2("ld18", 1'b1, 1'b0, 32'h18, 32'd0, 32'h18, 32'd0, 1'b1, 1'b0, 32'h0BADF00D);

        // Misaligned load: error, ReadData held, mem[4] untouched.
        do2("ld13", 1'b1, 1'b0, 32'h13, 32'd0, 32'h13, 32'd0, 1'b0, 1'b1, 32'h0BADF00D);
        do2("ld10b", 1'b1, 1'b0, 32'h10, 32'd0, 32'h10, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);

        // Out-of-range store (aliases word 0 if unchecked) and both ops high.
        do2("st400", 1'b0, 1'b1, 32'h400, 32'h11111111, 32'h400, 32'h11111111, 1'b0, 1'b1, 32'hDEADBEEF);
        do2("ld00", 1'b1, 1'b0, 32'h0, 32'd0, 32'h0, 32'd0, 1'b1, 1'b0, 32'hA5A50000);
        do2("both", 1'b1, 1'b1, 32'h10, 32'h22222222, 32'h10, 32'h22222222, 1'b0, 1'b1, 32'hA5A50000);
        do2("ld10c", 1'b1, 1'b0, 32'h10, 32'd0, 32'h10, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);

        // Inputs changed during WAIT are ignored.
        do2("st14", 1'b0, 1'b1, 32'h14, 32'h5555AAAA, 32'h18, 32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF);
        do2("ld18b", 1'b1, 1'b0, 32'h18, 32'd0, 32'h18, 32'd0, 1'b1, 1'b0, 32'h0BADF00D);
        do2("ld14", 1'b1, 1'b0, 32'h14, 32'd0, 32'h18, 32'd0, 1'b1, 1'b0, 32'h5555AAAA);

        // Reset during WAIT of a store: store dropped, array retained.
        do2("st20", 1'b0, 1'b1, 32'h20, 32'hCAFE0001, 32'h20, 32'hCAFE0001, 1'b0, 1'b0, 32'h5555AAAA);
        rd2 = 1'b0; wr2 = 1'b1; a2 = 32'h20; d2 = 32'hFFFF0000;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstw.busy_low", 32'(busy2), 32'd0);
        tick();
        chk("rstw.q",    q2,         32'd0);
        chk("rstw.rv",   32'(rv2),   32'd0);
        chk("rstw.err",  32'(err2),  32'd0);
        chk("rstw.busy", 32'(busy2), 32'd0);
        rst_n = 1'b1;
        wr2 = 1'b0;
        tick();
        do2("ld20", 1'b1, 1'b0, 32'h20, 32'd0, 32'h20, 32'd0, 1'b1, 1'b0, 32'hCAFE0001);
        do2("st20b", 1'b0, 1'b1, 32'h20, 32'h77778888, 32'h20, 32'h77778888, 1'b0, 1'b0, 32'hCAFE0001);
        do2("ld20b", 1'b1, 1'b0, 32'h20, 32'd0, 32'h20, 32'd0, 1'b1, 1'b0, 32'h77778888);

        // LATENCY=1: preload, then back-to-back loads.
        do1("l1.st0", 1'b0, 1'b1, 32'h0, 32'h01010101, 1'b0, 32'd0);
        do1("l1.st4", 1'b0, 1'b1, 32'h4, 32'h02020202, 1'b0, 32'd0);
        do1("l1.ld0", 1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 32'h01010101);
        do1("l1.ld4", 1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 32'h02020202);
        #1;
        chk("l1.idle_busy", 32'(busy1), 32'd0);
        chk("l1.idle_rv",   32'(rv1),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
